// File: rtl/video_cmd_regs.sv
// UART-driven control register file: pending bank written by byte commands,
// copied to the active bank once per vertical-blanking rising edge.
module video_cmd_regs #(
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2170
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_rx_valid,
    input  logic                  i_vblank,
    input  logic                  i_tx_ready,
    output logic [7:0]            o_tx_byte,
    output logic                  o_tx_valid,
    output logic [8*NUM_REGS-1:0] o_regs,
    output logic                  o_apply_stb,
    output logic [1:0]            o_status
);

    localparam int unsigned REG_W = 8 * NUM_REGS;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] NUM_REGS8 = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [6:0]         addr_q, addr_d;
    logic [REG_W-1:0]   pend_q;
    logic [REG_W-1:0]   act_q;
    logic [7:0]         tx_byte_q;
    logic               tx_valid_q;
    logic               apply_stb_q;
    logic [1:0]         status_q;
    logic               vblank_q;

    logic               resp_c;
    logic [7:0]         resp_byte_c;
    logic               wr_en_c;
    logic               timeout_c;
    logic [7:0]         rd_data_c;
    logic               vblank_rise_c;

    function automatic logic addr_ok(input logic [6:0] a);
        return {1'b0, a} < NUM_REGS8;
    endfunction

    // Read mux: pending-bank byte selected by the header address
    always_comb begin
        rd_data_c = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (i_rx_byte[6:0] == 7'(k)) begin
                rd_data_c = pend_q[8*k +: 8];
            end
        end
    end

    assign vblank_rise_c = i_vblank & ~vblank_q;

    // Command parser next-state and per-cycle actions
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        addr_d      = addr_q;
        resp_c      = 1'b0;
        resp_byte_c = '0;
        wr_en_c     = 1'b0;
        timeout_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (i_rx_valid) begin
                    if (i_rx_byte[7]) begin
                        state_d = ST_WAIT_DATA;
                        addr_d  = i_rx_byte[6:0];
                    end else begin
                        resp_c      = 1'b1;
                        resp_byte_c = addr_ok(i_rx_byte[6:0]) ? rd_data_c : NAK_BYTE;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (i_rx_valid) begin
                    state_d = ST_IDLE;
                    resp_c  = 1'b1;
                    if (addr_ok(addr_q)) begin
                        wr_en_c     = 1'b1;
                        resp_byte_c = ACK_BYTE;
                    end else begin
                        resp_byte_c = NAK_BYTE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_c = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Parser state, timeout counter and latched write address
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
        end
    end

    // Register banks; copy samples pending before any same-cycle write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en_c && (addr_q == 7'(k))) begin
                    pend_q[8*k +: 8] <= i_rx_byte;
                end
            end
            if (vblank_rise_c) begin
                act_q <= pend_q;
            end
        end
    end

    // Vblank edge detector and apply strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vblank_q    <= 1'b0;
            apply_stb_q <= 1'b0;
        end else begin
            vblank_q    <= i_vblank;
            apply_stb_q <= vblank_rise_c;
        end
    end

    // Single-entry response holding register with sticky overrun/timeout flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            status_q   <= '0;
        end else begin
            if (tx_valid_q && i_tx_ready) begin
                tx_valid_q <= 1'b0;
            end
            if (resp_c) begin
                if (!tx_valid_q || i_tx_ready) begin
                    tx_valid_q <= 1'b1;
                    tx_byte_q  <= resp_byte_c;
                end else begin
                    status_q[1] <= 1'b1;
                end
            end
            if (timeout_c) begin
                status_q[0] <= 1'b1;
            end
        end
    end

    assign o_tx_byte   = tx_byte_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_regs      = act_q;
    assign o_apply_stb = apply_stb_q;
    assign o_status    = status_q;

endmodule

// File: tb/tb_video_cmd_regs.sv
// Bench for video_cmd_regs: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_video_cmd_regs;

    localparam int unsigned NREG = 4;
    localparam int unsigned TO   = 50;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [7:0]        i_rx_byte = 8'h00;
    logic              i_rx_valid = 1'b0;
    logic              i_vblank = 1'b0;
    logic              i_tx_ready = 1'b1;
    logic [7:0]        o_tx_byte;
    logic              o_tx_valid;
    logic [8*NREG-1:0] o_regs;
    logic              o_apply_stb;
    logic [1:0]        o_status;

    int checks   = 0;
    int failures = 0;
    int dut_deliv = 0;

    video_cmd_regs #(.NUM_REGS(NREG), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_byte   (i_rx_byte),
        .i_rx_valid  (i_rx_valid),
        .i_vblank    (i_vblank),
        .i_tx_ready  (i_tx_ready),
        .o_tx_byte   (o_tx_byte),
        .o_tx_valid  (o_tx_valid),
        .o_regs      (o_regs),
        .o_apply_stb (o_apply_stb),
        .o_status    (o_status)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: command-level view of the register file
    bit         m_wait;
    int         m_addr;
    int         m_cnt;
    logic [7:0] m_pend [NREG];
    logic [7:0] m_act  [NREG];
    bit         m_txv;
    logic [7:0] m_txb;
    bit         m_stb;
    bit         m_ovr;
    bit         m_to;
    bit         m_vbp;

    task automatic model_reset();
        m_wait = 0; m_addr = 0; m_cnt = 0;
        for (int k = 0; k < int'(NREG); k++) begin
            m_pend[k] = 8'h00;
            m_act[k]  = 8'h00;
        end
        m_txv = 0; m_txb = 8'h00; m_stb = 0; m_ovr = 0; m_to = 0; m_vbp = 0;
    endtask

    task automatic model_clk();
        logic [7:0] old_pend [NREG];
        bit         resp;
        logic [7:0] rbyte;
        int         a;
        old_pend = m_pend;
        resp  = 0;
        rbyte = 8'h00;
        a     = int'(i_rx_byte[6:0]);
        if (!m_wait) begin
            if (i_rx_valid) begin
                if (i_rx_byte[7]) begin
                    m_wait = 1; m_addr = a; m_cnt = 0;
                end else begin
                    resp  = 1;
                    rbyte = (a < int'(NREG)) ? m_pend[a] : 8'h15;
                end
            end
        end else if (i_rx_valid) begin
            m_wait = 0;
            resp   = 1;
            if (m_addr < int'(NREG)) begin
                m_pend[m_addr] = i_rx_byte;
                rbyte = 8'h06;
            end else begin
                rbyte = 8'h15;
            end
        end else if (m_cnt == int'(TO) - 1) begin
            m_wait = 0;
            m_to   = 1;
        end else begin
            m_cnt++;
        end
        m_stb = i_vblank && !m_vbp;
        if (m_stb) m_act = old_pend;
        m_vbp = i_vblank;
        if (resp && m_txv && !i_tx_ready) begin
            m_ovr = 1;
        end else begin
            if (m_txv && i_tx_ready) m_txv = 0;
            if (resp) begin
                m_txv = 1;
                m_txb = rbyte;
            end
        end
    endtask

    function automatic logic [8*NREG-1:0] pack_act();
        logic [8*NREG-1:0] r;
        for (int k = 0; k < int'(NREG); k++) r[8*k +: 8] = m_act[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_tx_valid", 32'(o_tx_valid), 32'(m_txv));
        chk("model_tx_byte", 32'(o_tx_byte), 32'(m_txb));
        chk("model_regs", 32'(o_regs), 32'(pack_act()));
        chk("model_apply_stb", 32'(o_apply_stb), 32'(m_stb));
        chk("model_status", 32'(o_status), 32'({m_ovr, m_to}));
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked 1ns later
    task automatic step();
        if (o_tx_valid && i_tx_ready && i_rst_n) dut_deliv++;
        @(posedge i_clk);
        if (i_rst_n) model_clk();
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic rv, input logic [7:0] rb, input logic vb, input logic rdy);
        i_rx_valid = rv;
        i_rx_byte  = rb;
        i_vblank   = vb;
        i_tx_ready = rdy;
        step();
    endtask

    typedef struct packed {
        logic        rv;
        logic [7:0]  rb;
        logic        vb;
        logic        rdy;
        logic        etv;
        logic [7:0]  etb;
        logic [31:0] eregs;
        logic        estb;
        logic [1:0]  est;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [7:0] rb, input logic vb,
                                input logic etv, input logic [7:0] etb,
                                input logic [31:0] eregs, input logic estb);
        vec_t v;
        v.rv = rv; v.rb = rb; v.vb = vb; v.rdy = 1'b1;
        v.etv = etv; v.etb = etb; v.eregs = eregs; v.estb = estb; v.est = 2'b00;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        tbl[0]  = mk(1, 8'h81, 0, 0, 8'h00, 32'h0000_0000, 0);
        tbl[1]  = mk(1, 8'h5A, 0, 1, 8'h06, 32'h0000_0000, 0);
        tbl[2]  = mk(0, 8'h00, 0, 0, 8'h06, 32'h0000_0000, 0);
        tbl[3]  = mk(1, 8'h01, 0, 1, 8'h5A, 32'h0000_0000, 0);
        tbl[4]  = mk(1, 8'h05, 0, 1, 8'h15, 32'h0000_0000, 0);
        tbl[5]  = mk(0, 8'h00, 1, 0, 8'h15, 32'h0000_5A00, 1);
        tbl[6]  = mk(0, 8'h00, 1, 0, 8'h15, 32'h0000_5A00, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 8'h15, 32'h0000_5A00, 0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 8'h15, 32'h0000_5A00, 0);
        tbl[9]  = mk(1, 8'h85, 0, 0, 8'h15, 32'h0000_5A00, 0);
        tbl[10] = mk(1, 8'h11, 0, 1, 8'h15, 32'h0000_5A00, 0);
        tbl[11] = mk(1, 8'h01, 0, 1, 8'h5A, 32'h0000_5A00, 0);
        tbl[12] = mk(1, 8'h02, 0, 1, 8'h00, 32'h0000_5A00, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 8'h00, 32'h0000_5A00, 0);

        // Reset state
        model_reset();
        #1;
        compare_all();
        chk("reset_regs", 32'(o_regs), 32'h0);
        repeat (3) cyc(0, 8'h00, 0, 1);
        i_rst_n = 1'b1;

        // Directed write/read/NAK/vblank table
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rv, tbl[i].rb, tbl[i].vb, tbl[i].rdy);
            chk($sformatf("tbl%0d_tx_valid", i), 32'(o_tx_valid), 32'(tbl[i].etv));
            chk($sformatf("tbl%0d_tx_byte", i), 32'(o_tx_byte), 32'(tbl[i].etb));
            chk($sformatf("tbl%0d_regs", i), 32'(o_regs), tbl[i].eregs);
            chk($sformatf("tbl%0d_apply_stb", i), 32'(o_apply_stb), 32'(tbl[i].estb));
            chk($sformatf("tbl%0d_status", i), 32'(o_status), 32'(tbl[i].est));
        end

        // Data byte on the last counted cycle is still accepted
        cyc(1, 8'h80, 0, 1);
        cyc(1, 8'h33, 0, 1);
        cyc(1, 8'h80, 0, 1);
        repeat (TO - 1) cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h44, 0, 1);
        chk("to_edge_ack", 32'({o_tx_valid, o_tx_byte}), 32'h106);
        chk("to_edge_status", 32'(o_status), 32'h0);

        // Timeout: no response, sticky flag, next byte is a header
        cyc(1, 8'h80, 0, 1);
        repeat (TO - 1) cyc(0, 8'h00, 0, 1);
        chk("to_before", 32'(o_status), 32'h0);
        cyc(0, 8'h00, 0, 1);
        chk("to_status", 32'(o_status), 32'h1);
        chk("to_no_resp", 32'(o_tx_valid), 32'h0);
        cyc(1, 8'h00, 0, 1);
        chk("to_read_reg0", 32'({o_tx_valid, o_tx_byte}), 32'h144);

        // Overrun with transmitter stalled, then exactly one delivery
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h01, 0, 0);
        chk("ovr_keep", 32'({o_tx_valid, o_tx_byte}), 32'h144);
        chk("ovr_status", 32'(o_status), 32'h3);
        dut_deliv = 0;
        repeat (4) cyc(0, 8'h00, 0, 1);
        chk("ovr_one_delivery", 32'(dut_deliv), 32'd1);
        chk("ovr_drained", 32'(o_tx_valid), 32'h0);

        // Write completing in the copy cycle lands at the following frame
        cyc(1, 8'h82, 0, 1);
        cyc(1, 8'h77, 1, 1);
        chk("coll_old_active", 32'(o_regs[23:16]), 32'h00);
        chk("coll_stb", 32'(o_apply_stb), 32'h1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 0, 1);
        cyc(0, 8'h00, 1, 1);
        chk("coll_new_active", 32'(o_regs[23:16]), 32'h77);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic       rv;
            logic [7:0] rb;
            logic       vb;
            rv = ((n % 500) < 60) ? 1'b0 : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rb = 8'($urandom);
            else rb = {1'($urandom), 7'($urandom_range(0, 5))};
            vb = ($urandom_range(0, 39) == 0) ? ~i_vblank : i_vblank;
            cyc(rv, rb, vb, 1'($urandom_range(0, 3) != 0));
        end

        // Reset mid-command, release with vblank high
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h83, 0, 1);
        i_rst_n  = 1'b0;
        i_vblank = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_async_all", 32'({o_tx_valid, o_tx_byte, o_apply_stb, o_status}), 32'h0);
        chk("rst_async_regs", 32'(o_regs), 32'h0);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 1, 1);
        i_rst_n = 1'b1;
        cyc(0, 8'h00, 1, 1);
        chk("rst_vblank_copy", 32'(o_apply_stb), 32'h1);
        cyc(1, 8'h01, 1, 1);
        chk("rst_header_read", 32'({o_tx_valid, o_tx_byte}), 32'h100);
        chk("rst_single_copy", 32'(o_apply_stb), 32'h0);
        repeat (3) cyc(0, 8'h00, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
